// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad emulator: FSM state type, bounce
// timing constants and the hex-key to (row, col) lookup.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int BOUNCE_LEN    = 64;
  localparam int BOUNCE_PERIOD = 8;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] c;
  } key_pos_t;

  // Physical position of a hex key on the 4x4 matrix
  function automatic key_pos_t key_to_pos(input logic [3:0] key);
    key_pos_t p;
    case (key)
      4'h1:    p = {2'd0, 2'd0};
      4'h2:    p = {2'd0, 2'd1};
      4'h3:    p = {2'd0, 2'd2};
      4'hA:    p = {2'd0, 2'd3};
      4'h4:    p = {2'd1, 2'd0};
      4'h5:    p = {2'd1, 2'd1};
      4'h6:    p = {2'd1, 2'd2};
      4'hB:    p = {2'd1, 2'd3};
      4'h7:    p = {2'd2, 2'd0};
      4'h8:    p = {2'd2, 2'd1};
      4'h9:    p = {2'd2, 2'd2};
      4'hC:    p = {2'd2, 2'd3};
      4'h0:    p = {2'd3, 2'd0};
      4'hF:    p = {2'd3, 2'd1};
      4'hE:    p = {2'd3, 2'd2};
      4'hD:    p = {2'd3, 2'd3};
      default: p = {2'd0, 2'd0};
    endcase
    return p;
  endfunction

  // Active-low row pattern with only row r pulled low
  function automatic logic [3:0] row_pattern(input logic [1:0] r);
    return ~(4'b0001 << r);
  endfunction

endpackage

// File: rtl/keypad_key_fifo.sv
// DEPTH x 4 key queue. Pointers wrap naturally because DEPTH is a power
// of two. A push is accepted while full if the same cycle also pops.
module keypad_key_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  input  logic       pop,
  output logic       empty,
  output logic [3:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          take;

  assign empty     = (count == '0);
  assign take      = pop && !empty;
  assign key_ready = (count != FULL_COUNT) || take;
  assign push      = key_valid && key_ready;
  assign head      = mem[rd_ptr];

  // Store accepted keys at the write pointer
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= key_code;
    end
  end

  // Advance pointers and occupancy on push/pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (take) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, take})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/keypad_emulator.sv
// Keypad emulator: pops queued hex keys and presses them on a 4x4
// matrix by pulling the key's row low whenever the scanner strobes its
// column. Optional contact bounce is enabled by KEYPAD_EMU_BOUNCE_EN.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int HOLD_CYCLES = 500_000,
  parameter int GAP_CYCLES  = 500_000,
  parameter int DEPTH       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       pressing,
  output logic       busy
);

  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [3:0]    active_key;
  logic [3:0]    head;
  logic          empty;
  logic          pop;

  assign pop     = (state == ST_IDLE) && !empty;
  assign busy    = !empty || (state != ST_IDLE);
  assign cnt_inc = cnt + CW'(1);

  keypad_key_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .pop       (pop),
    .empty     (empty),
    .head      (head)
  );

  // Row drive for a key given the column strobes and contact condition
  function automatic logic [3:0] drive_row(input logic [3:0] key,
                                           input logic [3:0] col_in,
                                           input logic       closed);
    key_pos_t p;
    p = key_to_pos(key);
    if (closed && !col_in[p.c]) begin
      return row_pattern(p.r);
    end else begin
      return 4'b1111;
    end
  endfunction

`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int BP_BIT = $clog2(BOUNCE_PERIOD);

  // Press bounce: closed, open, closed ... then settled closed
  function automatic logic press_closed(input logic [CW-1:0] k);
    return (k >= CW'(BOUNCE_LEN)) || !k[BP_BIT];
  endfunction

  // Release bounce: open, closed, open ... then settled open
  function automatic logic gap_closed(input logic [CW-1:0] k);
    return (k < CW'(BOUNCE_LEN)) && k[BP_BIT];
  endfunction
`endif

  // Press sequencer and registered row / pressing outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      active_key <= 4'h0;
      row        <= 4'b1111;
      pressing   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            active_key <= head;
            cnt        <= '0;
            state      <= ST_PRESS;
            pressing   <= 1'b1;
            row        <= drive_row(head, col, 1'b1);
          end else begin
            row        <= 4'b1111;
            pressing   <= 1'b0;
          end
        end
        ST_PRESS: begin
          if (cnt == CW'(HOLD_CYCLES - 1)) begin
            cnt      <= '0;
            state    <= ST_GAP;
            pressing <= 1'b0;
            row      <= 4'b1111;
          end else begin
            cnt      <= cnt_inc;
            pressing <= 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
            row      <= drive_row(active_key, col, press_closed(cnt_inc));
`else
            row      <= drive_row(active_key, col, 1'b1);
`endif
          end
        end
        ST_GAP: begin
          pressing <= 1'b0;
          if (cnt == CW'(GAP_CYCLES - 1)) begin
            cnt   <= '0;
            state <= ST_IDLE;
            row   <= 4'b1111;
          end else begin
            cnt   <= cnt_inc;
`ifdef KEYPAD_EMU_BOUNCE_EN
            row   <= drive_row(active_key, col, gap_closed(cnt_inc));
`else
            row   <= 4'b1111;
`endif
          end
        end
        default: begin
          state    <= ST_IDLE;
          cnt      <= '0;
          row      <= 4'b1111;
          pressing <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Randomized scoreboard bench for keypad_emulator. A time-budget model
// predicts acceptance, busy, pressing and the order of pressed keys; a
// monitor pops expected keys at each press start and checks the row
// response against the key layout table.
module tb_keypad_emulator;

  localparam int HOLD  = 100;
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int GAP   = 80;
`else
  localparam int GAP   = 50;
`endif
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic [3:0] col = 4'hF;
  logic       key_ready;
  logic [3:0] row;
  logic       pressing;
  logic       busy;

  keypad_emulator #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .col       (col),
    .row       (row),
    .pressing  (pressing),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic [3:0] keymap [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                                '{4'h4, 4'h5, 4'h6, 4'hB},
                                '{4'h7, 4'h8, 4'h9, 4'hC},
                                '{4'h0, 4'hF, 4'hE, 4'hD}};

  // Reference model: FIFO contents plus cycles until the emulator is idle
  int  mq[$];
  int  exp_keys[$];
  int  m_left = 0;
  bit  m_accepted = 0;
  int  col_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic find_pos(input logic [3:0] key, output int r, output int c);
    r = 0;
    c = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (keymap[i][j] == key) begin
          r = i;
          c = j;
        end
  endtask

  task automatic model_step();
    bit pop_now;
    bit rdy;
    pop_now = (m_left == 0) && (mq.size() > 0);
    rdy     = (mq.size() < DEPTH) || pop_now;
    if (pop_now) begin
      exp_keys.push_back(mq.pop_front());
      m_left = HOLD + GAP;
    end else if (m_left > 0) begin
      m_left--;
    end
    m_accepted = key_valid && rdy;
    if (m_accepted) mq.push_back(int'(key_code));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("pressing", pressing, (m_left > GAP) ? 1 : 0);
    check("busy", busy, (mq.size() > 0 || m_left > 0) ? 1 : 0);
    check("key_ready", key_ready, (mq.size() < DEPTH || (m_left == 0 && mq.size() > 0)) ? 1 : 0);
    if (col_mode == 0) begin
      if ($urandom_range(0, 1) == 1) col = ~(4'b0001 << 2'($urandom_range(0, 3)));
      else col = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic enqueue(input logic [3:0] k);
    int n;
    key_valid = 1'b1;
    key_code  = k;
    n = 0;
    do begin
      step();
      n++;
    end while (!m_accepted && n < 1000);
    if (!m_accepted) begin
      checks++;
      fails++;
      $display("FAIL enqueue_timeout: key %0h not accepted within %0d cycles", k, n);
    end
    key_valid = 1'b0;
  endtask

  // Monitor: pop expected key on each press start and check row every cycle
  logic [3:0] col_edge = 4'hF;
  always @(posedge clk) col_edge <= col;

  bit         prev_p = 0;
  bit         have_key = 0;
  logic [3:0] cur_key = 4'h0;
  int         k = 0;
  int         g = 0;

  always @(negedge clk) begin : monitor
    int r;
    int c;
    bit closed;
    logic [3:0] erow;
    if (rst) begin
      have_key = 0;
      prev_p   = 0;
      k = 0;
      g = 0;
    end else begin
      if (pressing && !prev_p) begin
        if (have_key) check("gap_min", (g >= GAP + 1) ? 1 : 0, 1);
        if (exp_keys.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL press_start: got unexpected press expected none at %0t", $time);
          have_key = 0;
        end else begin
          cur_key  = 4'(exp_keys.pop_front());
          have_key = 1;
        end
        k = 0;
      end
      if (!pressing && prev_p) begin
        check("press_len", k, HOLD);
        g = 0;
      end
      closed = 0;
`ifdef KEYPAD_EMU_BOUNCE_EN
      if (pressing) closed = (k >= 64) || ((k / 8) % 2 == 0);
      else if (have_key && g < 64) closed = ((g / 8) % 2 == 1);
`else
      if (pressing) closed = 1;
`endif
      find_pos(cur_key, r, c);
      erow = 4'hF;
      if (have_key && closed && col_edge[c] == 1'b0) erow[r] = 1'b0;
      check("row", row, erow);
      if (pressing) k++;
      else g++;
      prev_p = pressing;
    end
  end

  initial begin
    int n;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_row", row, 4'hF);
    check("rst_pressing", pressing, 0);
    check("rst_busy", busy, 0);
    check("rst_key_ready", key_ready, 1);
    @(posedge clk);
    #2 rst = 1'b0;

    // Key 5 scanned on column 1
    col_mode = 1;
    col = 4'b1101;
    enqueue(4'h5);
    repeat (HOLD + GAP + 10) step();

    // Key D: wrong column for one press, right column for the next
    col = 4'b1110;
    enqueue(4'hD);
    repeat (HOLD + GAP + 10) step();
    col = 4'b0111;
    enqueue(4'hD);
    repeat (HOLD + GAP + 10) step();

    // Back-to-back keys: queue fills and accepts on the pop cycle
    col_mode = 0;
    for (int i = 1; i <= 8; i++) enqueue(4'(i));

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      key_valid = ($urandom_range(0, 29) == 0);
      key_code  = 4'($urandom_range(0, 15));
      step();
    end
    key_valid = 1'b0;
    n = 0;
    while ((m_left > 0 || mq.size() > 0) && n < 2000) begin
      step();
      n++;
    end

    // Reset at press clock 40 with more keys queued behind
    col_mode = 1;
    col = 4'b1011;
    enqueue(4'h9);
    enqueue(4'hA);
    enqueue(4'hB);
    n = 0;
    while (m_left != HOLD + GAP - 40 && n < 500) begin
      step();
      n++;
    end
    check("press40_reached", m_left, HOLD + GAP - 40);
    check("press40_row", row, 4'b1011);
    #1 rst = 1'b1;
    #1;
    check("arst_row", row, 4'hF);
    check("arst_pressing", pressing, 0);
    check("arst_busy", busy, 0);
    check("arst_key_ready", key_ready, 1);
    mq.delete();
    exp_keys.delete();
    m_left = 0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (HOLD + GAP + 10) step();

    check("sb_empty", exp_keys.size(), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/keypad_emulator.md
KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 Parameter HOLD_CYCLES, default 500_000: clocks a key contact stays closed (10 ms at 50 MHz).
REQ-002 Parameter GAP_CYCLES, default 500_000: minimum open-contact clocks between consecutive presses.
REQ-003 Parameter DEPTH, default 4, power of two >= 2: key queue entries.
REQ-004 clk  in  1  system clock, 50 MHz.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 key_valid  in  1  enqueue request for key_code.
REQ-007 key_code  in  4  hex key to press, 0x0-0xF.
REQ-008 key_ready  out  1  queue not full; key accepted when key_valid && key_ready at a posedge.
REQ-009 col  in  4  column scan strobes from the keypad scanner, active-low, one column low at a time.
REQ-010 row  out  4  row sense lines, active-low, idle 4'b1111.
REQ-011 pressing  out  1  contact currently closed (PRESS state).
REQ-012 busy  out  1  queue non-empty or state != IDLE.

Function
REQ-013 Layout, as (row, col): 1,2,3,A = row 0, cols 0-3; 4,5,6,B = row 1; 7,8,9,C = row 2; 0,F,E,D = row 3.
REQ-014 Queue is a FIFO of DEPTH entries with separate read and write pointers that wrap modulo DEPTH.
REQ-015 key_ready = 0 when the queue holds DEPTH entries; a key_valid while full is dropped, and the count does not change.
REQ-016 Simultaneous enqueue and dequeue in one cycle: count unchanged, both pointers advance; this is legal when the queue is full.
REQ-017 FSM states IDLE, PRESS, GAP; the counter width is wide enough for max(HOLD_CYCLES, GAP_CYCLES).
REQ-018 IDLE: when the queue is non-empty, pop the head into the active-key register, clear the counter, and enter PRESS in the same cycle.
REQ-019 PRESS: the counter increments each clock; at count == HOLD_CYCLES-1, clear the counter and enter GAP.
REQ-020 GAP: row = 4'b1111; at count == GAP_CYCLES-1, go to IDLE, which pops the next key on the following cycle if one is present.
REQ-021 In PRESS, if col[c_active] == 0, row is registered with bit r_active = 0 and all other bits = 1; otherwise row = 4'b1111.
REQ-022 Latency from a col change to the row response is exactly 1 clock.
REQ-023 col with several bits low is treated per-bit: the active row is driven low if col[c_active] == 0.
REQ-024 pressing = 1 exactly while in PRESS; it is registered.

Reset
REQ-025 rst = 1 forces IDLE, empties the queue, clears both pointers and the counter, and sets row = 4'b1111, pressing = 0, busy = 0, key_ready = 1.
REQ-026 rst asserted mid-PRESS releases the contact (row = 4'b1111) immediately and asynchronously; the queued keys are lost.

Configuration
REQ-027 Macro KEYPAD_EMU_BOUNCE_EN: when defined, the first 64 clocks of PRESS toggle the contact every 8 clocks, starting closed (closed, open, closed, ...), so the key bounces before settling closed. The first 64 clocks of GAP toggle the same way starting open (open, closed, open, ...), so the key bounces before settling open.
REQ-028 While the contact is open during a bounce, row = 4'b1111 regardless of col.
REQ-029 When KEYPAD_EMU_BOUNCE_EN is undefined, the contact is ideal, REQ-021 applies unchanged, and no bounce logic is synthesized.
REQ-030 Bounce does not alter PRESS or GAP duration; HOLD_CYCLES and GAP_CYCLES must be > 64 when bounce is enabled.

Structure
REQ-031 Shared package keypad_pkg holds the state enum typedef, a key-to-(row, col) lookup function, and constants BOUNCE_LEN = 64 and BOUNCE_PERIOD = 8.
REQ-032 Sub-module keypad_key_fifo implements the DEPTH x 4 queue with key_valid/key_ready in and pop/empty out; the FSM and row driver live in keypad_emulator.

Verification
REQ-033 Use HOLD_CYCLES = 100 and GAP_CYCLES = 50. Enqueue key 0x5 and scan with col = 4'b1101. Required: row = 4'b1101 one clock after the scan, for 100 clocks; then 4'b1111.
REQ-034 Enqueue key 0xD and hold col = 4'b1110 throughout PRESS. Required: row = 4'b1111 for the whole press (column mismatch); the press must be observed on col = 4'b0111 instead.
REQ-035 Enqueue keys 1, 2, 3, 4, 5 back-to-back without a pop. Required: key_ready = 0 after the 4th enqueue while pressing=0 and the FIFO is unpopped; the keys then press in order 1, 2, 3, 4 with a 50-clock gap; a 5th key offered only after key_ready returns to 1 presses last.
REQ-036 Fill the queue and present key_valid on the same cycle IDLE pops. Required: both operations occur and the count stays at 4.
REQ-037 Assert rst at PRESS clock 40. Required: row = 4'b1111, pressing = 0 and busy = 0 immediately, with no residual press after release.
REQ-038 With KEYPAD_EMU_BOUNCE_EN defined, enqueue key 0x0 and scan with col = 4'b1110. Required: row[3] alternates every 8 clocks for 64 clocks, then stays 0 until clock 100.
